scarv_soc_bram_dual_pipe: RTL and testbench

Parametrised dual-port byte-addressed BRAM for the SoC memory subsystem. Both ports share one clock. Over the single-cycle dual-port model it adds:
- configurable data width;
- a configurable read pipeline with per-port read-valid strobes;
- a selectable same-port read-during-write mode;
- deterministic same-word write-collision resolution with a collision pulse.

It backs instruction/data RAM where the interconnect needs registered read data and a valid qualifier.

---
 rtl/scarv_soc_bram_dual_pipe.sv | 135 +++++++++++++
 tb/tb_scarv_soc_bram_dual_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_soc_bram_dual_pipe.sv
// Dual-port byte-lane BRAM with configurable read pipeline, same-port
// read-during-write mode and deterministic same-word write collision handling.
module scarv_soc_bram_dual_pipe #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned DW          = 32,
   parameter int unsigned RD_LATENCY  = 1,
   parameter bit          WRITE_FIRST = 1'b0,
   parameter string       MEMH_FILE   = ""
) (
   input  logic                     clka,
   input  logic                     rsta,
   input  logic                     ena,
   input  logic [DW/8-1:0]          wea,
   input  logic [$clog2(DEPTH)-1:0] addra,
   input  logic [DW-1:0]            dina,
   output logic [DW-1:0]            douta,
   output logic                     douta_valid,
   input  logic                     enb,
   input  logic [DW/8-1:0]          web,
   input  logic [$clog2(DEPTH)-1:0] addrb,
   input  logic [DW-1:0]            dinb,
   output logic [DW-1:0]            doutb,
   output logic                     doutb_valid,
   output logic                     collision
);

   localparam int unsigned BW  = DW / 8;
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned OW  = $clog2(BW);
   localparam int unsigned WIW = AW - OW;

   logic [7:0]              mem_q [DEPTH];

   logic [1:0]              en_c;
   logic [1:0][BW-1:0]      we_c;
   logic [1:0][WIW-1:0]     widx_c;
   logic [1:0][DW-1:0]      din_c;
   logic [1:0][DW-1:0]      rd_sel_c;
   logic [DW-1:0]           out_dat_c [2];
   logic                    out_vld_c [2];

   logic                    same_word_c;
   logic [BW-1:0]           wr_a_c;
   logic [BW-1:0]           wr_b_c;
   logic                    coll_d;
   logic                    coll_q;
   logic                    unused_addr_c;

   assign en_c   = {enb, ena};
   assign we_c   = {web, wea};
   assign widx_c = {addrb[AW-1:OW], addra[AW-1:OW]};
   assign din_c  = {dinb, dina};

   // Sub-word address bits select nothing: accesses are always whole words.
   assign unused_addr_c = ^{addra[OW-1:0], addrb[OW-1:0]};

   // Pre-edge word per port, optionally merged with that port's own write lanes.
   always_comb begin
      rd_sel_c = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < int'(BW); i++) begin
            if (WRITE_FIRST && we_c[p][i]) begin
               rd_sel_c[p][8*i +: 8] = din_c[p][8*i +: 8];
            end else begin
               rd_sel_c[p][8*i +: 8] = mem_q[{widx_c[p], OW'(i)}];
            end
         end
      end
   end

   // Port A owns any lane both ports write in the same word.
   assign same_word_c = (widx_c[0] == widx_c[1]);
   assign wr_a_c      = ena ? wea : '0;
   assign wr_b_c      = (enb ? web : '0) & ~(same_word_c ? wr_a_c : '0);
   assign coll_d      = ena & enb & same_word_c & (|(wea & web));

   // Storage itself is never cleared; reset only blocks writes.
   always_ff @(posedge clka or posedge rsta) begin : p_mem_wr
      if (!rsta) begin
         for (int i = 0; i < int'(BW); i++) begin
            if (wr_a_c[i]) mem_q[{widx_c[0], OW'(i)}] <= dina[8*i +: 8];
            if (wr_b_c[i]) mem_q[{widx_c[1], OW'(i)}] <= dinb[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clka or posedge rsta) begin : p_coll
      if (rsta) coll_q <= 1'b0;
      else      coll_q <= coll_d;
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic          s1_vld_q;
      logic [DW-1:0] s1_dat_q;

      // Stage 1 loads data only for accepted reads so the output holds otherwise.
      always_ff @(posedge clka or posedge rsta) begin : p_s1
         if (rsta) begin
            s1_vld_q <= 1'b0;
            s1_dat_q <= '0;
         end else begin
            s1_vld_q <= en_c[p];
            if (en_c[p]) s1_dat_q <= rd_sel_c[p];
         end
      end

      if (RD_LATENCY == 2) begin : g_s2
         logic          s2_vld_q;
         logic [DW-1:0] s2_dat_q;

         always_ff @(posedge clka or posedge rsta) begin : p_s2
            if (rsta) begin
               s2_vld_q <= 1'b0;
               s2_dat_q <= '0;
            end else begin
               s2_vld_q <= s1_vld_q;
               if (s1_vld_q) s2_dat_q <= s1_dat_q;
            end
         end

         assign out_vld_c[p] = s2_vld_q;
         assign out_dat_c[p] = s2_dat_q;
      end else begin : g_s1
         assign out_vld_c[p] = s1_vld_q;
         assign out_dat_c[p] = s1_dat_q;
      end
   end

   assign douta       = out_dat_c[0];
   assign douta_valid = out_vld_c[0];
   assign doutb       = out_dat_c[1];
   assign doutb_valid = out_vld_c[1];
   assign collision   = coll_q;

endmodule

// File: tb/tb_scarv_soc_bram_dual_pipe.sv
// Directed bench: three 32-bit instances (old-data, write-first, 2-stage) share
// one stimulus bundle; a 64-bit instance covers wide byte lanes.
module tb_scarv_soc_bram_dual_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        ena = 0, enb = 0;
   logic [3:0]  wea = 0, web = 0;
   logic [9:0]  addra = 0, addrb = 0;
   logic [31:0] dina = 0, dinb = 0;
   logic [31:0] douta32 [3];
   logic [31:0] doutb32 [3];
   logic        va [3];
   logic        vb [3];
   logic        col [3];

   logic        e_ena = 0, e_enb = 0;
   logic [7:0]  e_wea = 0, e_web = 0;
   logic [9:0]  e_addra = 0, e_addrb = 0;
   logic [63:0] e_dina = 0, e_dinb = 0, e_douta, e_doutb;
   logic        e_va, e_vb, e_col;

   int total = 0;
   int bad   = 0;

   scarv_soc_bram_dual_pipe #(.DW(32), .RD_LATENCY(1), .WRITE_FIRST(1'b0)) u_d0 (
      .clka(clk), .rsta(rst),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta32[0]), .douta_valid(va[0]),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb32[0]), .doutb_valid(vb[0]),
      .collision(col[0]));

   scarv_soc_bram_dual_pipe #(.DW(32), .RD_LATENCY(1), .WRITE_FIRST(1'b1)) u_d1 (
      .clka(clk), .rsta(rst),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta32[1]), .douta_valid(va[1]),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb32[1]), .doutb_valid(vb[1]),
      .collision(col[1]));

   scarv_soc_bram_dual_pipe #(.DW(32), .RD_LATENCY(2), .WRITE_FIRST(1'b0)) u_d2 (
      .clka(clk), .rsta(rst),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta32[2]), .douta_valid(va[2]),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb32[2]), .doutb_valid(vb[2]),
      .collision(col[2]));

   scarv_soc_bram_dual_pipe #(.DW(64), .RD_LATENCY(1), .WRITE_FIRST(1'b0)) u_d3 (
      .clka(clk), .rsta(rst),
      .ena(e_ena), .wea(e_wea), .addra(e_addra), .dina(e_dina), .douta(e_douta), .douta_valid(e_va),
      .enb(e_enb), .web(e_web), .addrb(e_addrb), .dinb(e_dinb), .doutb(e_doutb), .doutb_valid(e_vb),
      .collision(e_col));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ena = 0; enb = 0; wea = 0; web = 0;
   endtask

   task automatic wra(input logic [9:0] a, input logic [3:0] m, input logic [31:0] d);
      ena = 1; wea = m; addra = a; dina = d;
   endtask

   task automatic wrb(input logic [9:0] a, input logic [3:0] m, input logic [31:0] d);
      enb = 1; web = m; addrb = a; dinb = d;
   endtask

   task automatic rda(input logic [9:0] a);
      ena = 1; wea = 0; addra = a;
   endtask

   task automatic rdb(input logic [9:0] a);
      enb = 1; web = 0; addrb = a;
   endtask

   task automatic test_reset();
      rst = 1; idle();
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({douta32[k], doutb32[k], va[k], vb[k], col[k]} !== 67'd0) begin
            bad++;
            $display("FAIL reset_outputs inst%0d: got %h want 0", k,
                     {douta32[k], doutb32[k], va[k], vb[k], col[k]});
         end
      end
      total++;
      if ({e_douta, e_doutb, e_va, e_vb, e_col} !== 131'd0) begin
         bad++;
         $display("FAIL reset_outputs_64: got %h want 0", {e_douta, e_doutb, e_va, e_vb, e_col});
      end
      rst = 0;
   endtask

   task automatic test_basic_read();
      wra(10'h010, 4'hF, 32'hA5A5_0F0F); tick();
      idle(); tick(); tick();
      rda(10'h010); tick();
      total++;
      if (va[0] !== 1'b1 || douta32[0] !== 32'hA5A5_0F0F) begin
         bad++;
         $display("FAIL basic_read_lat1: got v=%b d=%h want v=1 d=a5a50f0f", va[0], douta32[0]);
      end
      total++;
      if (va[2] !== 1'b0) begin
         bad++;
         $display("FAIL basic_read_lat2_early: got v=%b want 0", va[2]);
      end
      idle(); tick();
      total++;
      if (va[0] !== 1'b0 || douta32[0] !== 32'hA5A5_0F0F) begin
         bad++;
         $display("FAIL basic_read_hold: got v=%b d=%h want v=0 d=a5a50f0f", va[0], douta32[0]);
      end
      total++;
      if (va[2] !== 1'b1 || douta32[2] !== 32'hA5A5_0F0F) begin
         bad++;
         $display("FAIL basic_read_lat2: got v=%b d=%h want v=1 d=a5a50f0f", va[2], douta32[2]);
      end
      tick();
      total++;
      if (va[2] !== 1'b0 || douta32[2] !== 32'hA5A5_0F0F) begin
         bad++;
         $display("FAIL basic_read_lat2_hold: got v=%b d=%h want v=0 d=a5a50f0f", va[2], douta32[2]);
      end
   endtask

   task automatic test_byte_lane();
      e_enb = 1; e_web = 8'hFF; e_addrb = 10'h020; e_dinb = 64'h0; tick();
      e_web = 8'h0F; e_dinb = 64'h1111_2222_3333_4444; tick();
      total++;
      if (e_vb !== 1'b1 || e_doutb !== 64'h0) begin
         bad++;
         $display("FAIL byte_lane_rdw_old: got v=%b d=%h want v=1 d=0", e_vb, e_doutb);
      end
      e_enb = 0; e_web = 0;
      e_ena = 1; e_wea = 0; e_addra = 10'h020; tick();
      total++;
      if (e_va !== 1'b1 || e_douta !== 64'h0000_0000_3333_4444) begin
         bad++;
         $display("FAIL byte_lane_read: got v=%b d=%h want v=1 d=0000000033334444", e_va, e_douta);
      end
      e_addra = 10'h027; tick();
      total++;
      if (e_va !== 1'b1 || e_douta !== 64'h0000_0000_3333_4444) begin
         bad++;
         $display("FAIL byte_lane_lowbits: got v=%b d=%h want v=1 d=0000000033334444", e_va, e_douta);
      end
      e_ena = 0; tick();
   endtask

   task automatic test_rdw();
      wra(10'h040, 4'hF, 32'hDEAD_BEEF); tick();
      wra(10'h040, 4'h1, 32'h0000_00FF); rdb(10'h040); tick();
      total++;
      if (douta32[0] !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL rdw_read_old: got %h want deadbeef", douta32[0]);
      end
      total++;
      if (douta32[1] !== 32'hDEAD_BEFF) begin
         bad++;
         $display("FAIL rdw_write_first: got %h want deadbeff", douta32[1]);
      end
      total++;
      if (doutb32[0] !== 32'hDEAD_BEEF || doutb32[1] !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL rdw_cross_port: got %h/%h want deadbeef", doutb32[0], doutb32[1]);
      end
      total++;
      if (col[0] !== 1'b0) begin
         bad++;
         $display("FAIL rdw_no_collision: got %b want 0", col[0]);
      end
      idle(); rda(10'h040); tick();
      total++;
      if (douta32[0] !== 32'hDEAD_BEFF || douta32[1] !== 32'hDEAD_BEFF) begin
         bad++;
         $display("FAIL rdw_stored: got %h/%h want deadbeff", douta32[0], douta32[1]);
      end
      idle(); tick();
   endtask

   task automatic test_collision();
      wra(10'h080, 4'hF, 32'h0); wrb(10'h084, 4'hF, 32'h0); tick();
      total++;
      if (col[0] !== 1'b0) begin
         bad++;
         $display("FAIL coll_diff_words: got %b want 0", col[0]);
      end
      wra(10'h080, 4'h3, 32'hAAAA_AAAA); wrb(10'h080, 4'h6, 32'hBBBB_BBBB); tick();
      total++;
      if (col[0] !== 1'b1 || col[2] !== 1'b1) begin
         bad++;
         $display("FAIL coll_pulse: got %b/%b want 1/1", col[0], col[2]);
      end
      wra(10'h084, 4'h1, 32'h0000_0011); wrb(10'h084, 4'h8, 32'h2200_0000); tick();
      total++;
      if (col[0] !== 1'b0 || col[2] !== 1'b0) begin
         bad++;
         $display("FAIL coll_one_cycle: got %b/%b want 0/0", col[0], col[2]);
      end
      idle(); rda(10'h080); rdb(10'h084); tick();
      total++;
      if (col[0] !== 1'b0) begin
         bad++;
         $display("FAIL coll_disjoint_lanes: got %b want 0", col[0]);
      end
      total++;
      if (douta32[0] !== 32'h00BB_AAAA) begin
         bad++;
         $display("FAIL coll_stored: got %h want 00bbaaaa", douta32[0]);
      end
      total++;
      if (doutb32[0] !== 32'h2200_0011) begin
         bad++;
         $display("FAIL coll_disjoint_stored: got %h want 22000011", doutb32[0]);
      end
      idle(); tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] w [4];
      logic        ev;
      w[0] = 32'h1357_0000; w[1] = 32'h2468_1111; w[2] = 32'h369C_2222; w[3] = 32'h48D0_3333;
      wra(10'h100, 4'hF, w[0]); wrb(10'h104, 4'hF, w[1]); tick();
      wra(10'h108, 4'hF, w[2]); wrb(10'h10C, 4'hF, w[3]); tick();
      idle(); tick(); tick();
      for (int k = 0; k < 6; k++) begin
         if (k < 4) rda(10'(32'h100 + 4 * k));
         else       idle();
         tick();
         ev = (k >= 1 && k <= 4);
         total++;
         if (va[2] !== ev || (ev && douta32[2] !== w[k-1])) begin
            bad++;
            $display("FAIL b2b_lat2 k=%0d: got v=%b d=%h want v=%b d=%h", k, va[2], douta32[2],
                     ev, ev ? w[k-1] : 32'h0);
         end
         ev = (k < 4);
         total++;
         if (va[0] !== ev || (ev && douta32[0] !== w[k])) begin
            bad++;
            $display("FAIL b2b_lat1 k=%0d: got v=%b d=%h want v=%b d=%h", k, va[0], douta32[0],
                     ev, ev ? w[k] : 32'h0);
         end
      end
   endtask

   task automatic test_reset_midflight();
      wra(10'h200, 4'hF, 32'h1234_5678); tick();
      idle(); tick(); tick();
      rda(10'h200); tick();
      total++;
      if (va[0] !== 1'b1 || douta32[0] !== 32'h1234_5678) begin
         bad++;
         $display("FAIL rst_pre_read: got v=%b d=%h want v=1 d=12345678", va[0], douta32[0]);
      end
      idle(); rst = 1; #1;
      total++;
      if ({douta32[0], va[0], douta32[2], va[2], col[2]} !== 67'd0) begin
         bad++;
         $display("FAIL rst_async_clear: got %h want 0", {douta32[0], va[0], douta32[2], va[2], col[2]});
      end
      wra(10'h200, 4'hF, 32'hFFFF_FFFF); tick();
      total++;
      if ({va[0], va[2], douta32[2]} !== 34'd0) begin
         bad++;
         $display("FAIL rst_held: got %h want 0", {va[0], va[2], douta32[2]});
      end
      idle(); rst = 0; tick();
      total++;
      if (va[2] !== 1'b0 || va[0] !== 1'b0) begin
         bad++;
         $display("FAIL rst_no_late_valid: got %b/%b want 0/0", va[0], va[2]);
      end
      rda(10'h200); tick();
      total++;
      if (va[0] !== 1'b1 || douta32[0] !== 32'h1234_5678) begin
         bad++;
         $display("FAIL rst_write_blocked: got v=%b d=%h want v=1 d=12345678", va[0], douta32[0]);
      end
      idle(); tick();
      total++;
      if (va[2] !== 1'b1 || douta32[2] !== 32'h1234_5678) begin
         bad++;
         $display("FAIL rst_recover_lat2: got v=%b d=%h want v=1 d=12345678", va[2], douta32[2]);
      end
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_byte_lane();
      test_rdw();
      test_collision();
      test_back_to_back();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
